// File: rtl/rca_chunked_add_ctrl_pkg.sv
// Shared types and defaults for the chunked ripple-carry add sequencer.
// Imported by the interface, the controller and the chunk adder.
package rca_ctrl_pkg;

  localparam int CHUNK_W_DEF    = 10;
  localparam int NUM_CHUNKS_DEF = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/rca_chunked_add_ctrl_if.sv
// Operand-request and result handshakes of the chunked adder.
// slave is the sequencer side, master the producer/consumer side.
interface rca_chunked_add_ctrl_if
  import rca_ctrl_pkg::*;
#(
  parameter int CHUNK_W    = CHUNK_W_DEF,
  parameter int NUM_CHUNKS = NUM_CHUNKS_DEF
);

  localparam int W = CHUNK_W * NUM_CHUNKS;

  logic         i_valid;
  logic         o_ready;
  logic [W-1:0] i_add_term1;
  logic [W-1:0] i_add_term2;
  logic         i_carry_in;
  logic         o_valid;
  logic         i_ready;
  logic [W:0]   o_result;
  logic         o_busy;

  modport slave (
    input  i_valid,
    output o_ready,
    input  i_add_term1,
    input  i_add_term2,
    input  i_carry_in,
    output o_valid,
    input  i_ready,
    output o_result,
    output o_busy
  );

  modport master (
    output i_valid,
    input  o_ready,
    output i_add_term1,
    output i_add_term2,
    output i_carry_in,
    input  o_valid,
    output i_ready,
    input  o_result,
    input  o_busy
  );

endinterface

// File: rtl/rca_chunked_add_ctrl_chunk_adder.sv
// Combinational CHUNK_W-bit ripple-carry adder built from full adders.
// Shared by every chunk of the wide addition.
module rca_chunk_adder
  import rca_ctrl_pkg::*;
#(
  parameter int CHUNK_W = CHUNK_W_DEF
) (
  input  logic [CHUNK_W-1:0] a,
  input  logic [CHUNK_W-1:0] b,
  input  logic               cin,
  output logic [CHUNK_W-1:0] sum,
  output logic               cout
);

  logic [CHUNK_W:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < CHUNK_W; i++) begin : g_fa
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1]   = (a[i] & b[i])
                    | (a[i] & c[i])
                    | (b[i] & c[i]);
  end

  assign cout = c[CHUNK_W];

endmodule

// File: rtl/rca_chunked_add_ctrl.sv
// Wide adder that walks operands LSB chunk first through one narrow
// ripple stage, keeping the inter-chunk carry in a register.
module rca_chunked_add_ctrl
  import rca_ctrl_pkg::*;
#(
  parameter int CHUNK_W    = CHUNK_W_DEF,
  parameter int NUM_CHUNKS = NUM_CHUNKS_DEF
) (
  input logic                   i_clk,
  input logic                   i_rst,
  rca_chunked_add_ctrl_if.slave bus
);

  localparam int W  = CHUNK_W * NUM_CHUNKS;
  localparam int IW = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;

  localparam logic [1:0] IDLE = 2'(S_IDLE);
  localparam logic [1:0] ADD  = 2'(S_ADD);
  localparam logic [1:0] DONE = 2'(S_DONE);

  logic [1:0]         state;
  logic [IW-1:0]      idx;
  logic               carry;
  logic [W-1:0]       a_q;
  logic [W-1:0]       b_q;
  logic [W:0]         result;

  logic [CHUNK_W-1:0] a_ch;
  logic [CHUNK_W-1:0] b_ch;
  logic [CHUNK_W-1:0] sum;
  logic               cout;
  logic               last;

  always_comb begin
    a_ch = '0;
    b_ch = '0;
    for (int k = 0; k < NUM_CHUNKS; k++) begin
      if (idx == IW'(k)) begin
        a_ch = a_q[k*CHUNK_W +: CHUNK_W];
        b_ch = b_q[k*CHUNK_W +: CHUNK_W];
      end
    end
  end

  assign last = (idx == IW'(NUM_CHUNKS - 1));

  rca_chunk_adder #(
    .CHUNK_W (CHUNK_W)
  ) u_add (
    .a    (a_ch),
    .b    (b_ch),
    .cin  (carry),
    .sum  (sum),
    .cout (cout)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state  <= IDLE;
      idx    <= '0;
      carry  <= 1'b0;
      result <= '0;
      a_q    <= '0;
      b_q    <= '0;
    end else begin
      unique case (1'b1)
        (state == IDLE): begin
          if (bus.i_valid) begin
            a_q   <= bus.i_add_term1;
            b_q   <= bus.i_add_term2;
            carry <= bus.i_carry_in;
            idx   <= '0;
            state <= ADD;
          end
        end
        (state == ADD): begin
          for (int k = 0; k < NUM_CHUNKS; k++) begin
            if (idx == IW'(k)) begin
              result[k*CHUNK_W +: CHUNK_W] <= sum;
            end
          end
          carry <= cout;
          if (last) begin
            result[W] <= cout;
            state     <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        (state == DONE): begin
          if (bus.i_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Handshake outputs decode the state register only
  assign bus.o_ready  = (state == IDLE) && !i_rst;
  assign bus.o_valid  = (state == DONE);
  assign bus.o_busy   = (state == ADD) || (state == DONE);
  assign bus.o_result = result;

endmodule

// File: tb/tb_rca_chunked_add_ctrl.sv
// Randomized self-checking bench for rca_chunked_add_ctrl against a
// plain-arithmetic reference, with a second NUM_CHUNKS=1 instance.
module tb_rca_chunked_add_ctrl;

  localparam int W  = 40;
  localparam int N  = 4;
  localparam int W1 = 10;

  logic clk;
  logic rst;

  int checks;
  int errors;

  rca_chunked_add_ctrl_if #(.CHUNK_W(10), .NUM_CHUNKS(4)) bus0 ();
  rca_chunked_add_ctrl_if #(.CHUNK_W(10), .NUM_CHUNKS(1)) bus1 ();

  rca_chunked_add_ctrl #(.CHUNK_W(10), .NUM_CHUNKS(4)) dut0 (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus0.slave)
  );

  rca_chunked_add_ctrl #(.CHUNK_W(10), .NUM_CHUNKS(1)) dut1 (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W:0] ref_sum(input logic [W-1:0] a,
                                         input logic [W-1:0] b,
                                         input logic c);
    logic [W:0] s;
    s = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    return s;
  endfunction

  function automatic logic [W-1:0] rnd40();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[W-1:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op0(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic c, input string name);
    int n;
    int lat;
    logic [W:0] exp;
    exp = ref_sum(a, b, c);
    bus0.i_add_term1 = a;
    bus0.i_add_term2 = b;
    bus0.i_carry_in  = c;
    bus0.i_valid     = 1'b1;
    n = 0;
    while (!bus0.o_ready && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (!bus0.o_ready) begin
      errors++;
      $display("FAIL %s accept: o_ready=%0b required 1", name, bus0.o_ready);
    end
    tick();
    bus0.i_valid = 1'b0;
    bus0.i_add_term1 = rnd40();
    bus0.i_add_term2 = rnd40();
    lat = 0;
    while (!bus0.o_valid && lat < 20) begin
      tick();
      lat++;
    end
    checks++;
    if (lat !== N) begin
      errors++;
      $display("FAIL %s latency: got %0d required %0d", name, lat, N);
    end
    checks++;
    if (bus0.o_result !== exp) begin
      errors++;
      $display("FAIL %s result: got %h required %h", name,
               bus0.o_result, exp);
    end
    bus0.i_ready = 1'b1;
    tick();
    bus0.i_ready = 1'b0;
    checks++;
    if (bus0.o_valid !== 1'b0 || bus0.o_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s release: valid=%0b ready=%0b required 0 1", name,
               bus0.o_valid, bus0.o_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (bus0.o_valid !== 1'b0 || bus0.o_busy !== 1'b0 ||
        bus0.o_ready !== 1'b0 || bus0.o_result !== '0) begin
      errors++;
      $display("FAIL reset_state: v=%0b b=%0b r=%0b res=%h required 0 0 0 0",
               bus0.o_valid, bus0.o_busy, bus0.o_ready, bus0.o_result);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (bus0.o_ready !== 1'b1 || bus1.o_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: ready0=%0b ready1=%0b required 1 1",
               bus0.o_ready, bus1.o_ready);
    end
  endtask

  task automatic test_directed();
    run_op0(40'hFF_FFFF_FFFF, 40'h1, 1'b0, "all_ones_plus1");
    run_op0(40'h0, 40'h0, 1'b1, "cin_only");
    run_op0(40'h3FF, 40'h1, 1'b0, "chunk_boundary");
    run_op0(40'hFF_FFFF_FFFF, 40'hFF_FFFF_FFFF, 1'b1, "max_sum");
  endtask

  task automatic test_backpressure();
    logic [W:0] held;
    int n;
    bus0.i_add_term1 = 40'h12_3456_789A;
    bus0.i_add_term2 = 40'h0F_EDCB_A987;
    bus0.i_carry_in  = 1'b1;
    bus0.i_valid     = 1'b1;
    tick();
    bus0.i_valid = 1'b0;
    n = 0;
    while (!bus0.o_valid && n < 20) begin
      tick();
      n++;
    end
    held = ref_sum(40'h12_3456_789A, 40'h0F_EDCB_A987, 1'b1);
    for (int i = 0; i < 5; i++) begin
      bus0.i_valid     = i[0];
      bus0.i_add_term1 = rnd40();
      bus0.i_add_term2 = rnd40();
      checks++;
      if (bus0.o_valid !== 1'b1 || bus0.o_ready !== 1'b0 ||
          bus0.o_busy !== 1'b1 || bus0.o_result !== held) begin
        errors++;
        $display("FAIL bp_hold%0d: v=%0b r=%0b b=%0b res=%h required 1 0 1 %h",
                 i, bus0.o_valid, bus0.o_ready, bus0.o_busy,
                 bus0.o_result, held);
      end
      tick();
    end
    bus0.i_valid = 1'b0;
    bus0.i_ready = 1'b1;
    tick();
    bus0.i_ready = 1'b0;
    checks++;
    if (bus0.o_valid !== 1'b0 || bus0.o_busy !== 1'b0 ||
        bus0.o_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: v=%0b b=%0b r=%0b required 0 0 1",
               bus0.o_valid, bus0.o_busy, bus0.o_ready);
    end
  endtask

  task automatic test_reset_mid();
    bus0.i_add_term1 = 40'hAB_CDEF_0123;
    bus0.i_add_term2 = 40'h11_1111_1111;
    bus0.i_carry_in  = 1'b0;
    bus0.i_valid     = 1'b1;
    tick();
    bus0.i_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    checks++;
    if (bus0.o_valid !== 1'b0 || bus0.o_busy !== 1'b0 ||
        bus0.o_result !== '0 || bus0.o_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: v=%0b b=%0b r=%0b res=%h required 0 0 0 0",
               bus0.o_valid, bus0.o_busy, bus0.o_ready, bus0.o_result);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (bus0.o_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_ready: got %0b required 1", bus0.o_ready);
    end
    run_op0(40'd5, 40'd7, 1'b0, "after_reset_5p7");
  endtask

  task automatic test_random();
    logic [W:0] q[$];
    logic [W:0] exp;
    int accepts;
    int results;
    int cyc;
    accepts = 0;
    results = 0;
    cyc = 0;
    while ((accepts < 1000 || q.size() != 0) && cyc < 60000) begin
      bus0.i_valid     = (accepts < 1000) ? 1'($urandom_range(0, 1)) : 1'b0;
      bus0.i_ready     = 1'($urandom_range(0, 1));
      bus0.i_add_term1 = rnd40();
      bus0.i_add_term2 = rnd40();
      bus0.i_carry_in  = 1'($urandom_range(0, 1));
      if (bus0.o_valid && bus0.i_ready) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL rnd_extra_result: got %h required none",
                   bus0.o_result);
        end else begin
          exp = q.pop_front();
          if (bus0.o_result !== exp) begin
            errors++;
            $display("FAIL rnd_result%0d: got %h required %h", results,
                     bus0.o_result, exp);
          end
        end
        results++;
      end
      if (bus0.o_ready && bus0.i_valid) begin
        q.push_back(ref_sum(bus0.i_add_term1, bus0.i_add_term2,
                            bus0.i_carry_in));
        accepts++;
      end
      tick();
      cyc++;
    end
    bus0.i_valid = 1'b0;
    bus0.i_ready = 1'b0;
    checks++;
    if (results !== 1000 || accepts !== 1000) begin
      errors++;
      $display("FAIL rnd_count: results=%0d accepts=%0d required 1000 1000",
               results, accepts);
    end
  endtask

  task automatic test_single_chunk();
    int lat;
    logic [W1:0] exp;
    for (int t = 0; t < 4; t++) begin
      logic [W1-1:0] a;
      logic [W1-1:0] b;
      logic c;
      if (t == 0) begin
        a = 10'h3FF;
        b = 10'h001;
        c = 1'b0;
      end else begin
        a = 10'($urandom());
        b = 10'($urandom());
        c = 1'($urandom_range(0, 1));
      end
      exp = {1'b0, a} + {1'b0, b} + {{W1{1'b0}}, c};
      bus1.i_add_term1 = a;
      bus1.i_add_term2 = b;
      bus1.i_carry_in  = c;
      bus1.i_valid     = 1'b1;
      tick();
      bus1.i_valid = 1'b0;
      lat = 0;
      while (!bus1.o_valid && lat < 10) begin
        tick();
        lat++;
      end
      checks++;
      if (lat !== 1 || bus1.o_result !== exp) begin
        errors++;
        $display("FAIL nc1_op%0d: lat=%0d res=%h required 1 %h", t, lat,
                 bus1.o_result, exp);
      end
      bus1.i_ready = 1'b1;
      tick();
      bus1.i_ready = 1'b0;
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus0.i_valid = 1'b0;
    bus0.i_ready = 1'b0;
    bus0.i_add_term1 = '0;
    bus0.i_add_term2 = '0;
    bus0.i_carry_in = 1'b0;
    bus1.i_valid = 1'b0;
    bus1.i_ready = 1'b0;
    bus1.i_add_term1 = '0;
    bus1.i_add_term2 = '0;
    bus1.i_carry_in = 1'b0;
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid();
    test_random();
    test_single_chunk();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rca_chunked_add_ctrl.md
# rca_chunked_add_ctrl

Multi-cycle sequencer that performs a wide addition by time-multiplexing one narrow ripple-carry adder stage. Operands of NUM_CHUNKS×CHUNK_W bits are accepted on a valid/ready handshake, fed through the CHUNK_W-bit adder one chunk per cycle (LSB chunk first), with the inter-chunk carry held in a register. The full W+1-bit sum is returned on a second valid/ready handshake. The block sits between an operand producer and a result consumer in the adder test datapath and trades latency for adder area.

## Interface
Parameters:
- CHUNK_W, default 10: width of the shared ripple-carry stage.
- NUM_CHUNKS, default 4: chunks per operand, ≥1.
- W (localparam) = CHUNK_W*NUM_CHUNKS: operand width.

Ports:
- i_clk  in  1  single clock; all state updates on the rising edge.
- i_rst  in  1  reset, synchronous and active-high.
- i_valid  in  1  operand request.
- o_ready  out  1  block can accept operands.
- i_add_term1  in  W  operand A.
- i_add_term2  in  W  operand B.
- i_carry_in  in  1  carry into chunk 0.
- o_valid  out  1  result available.
- i_ready  in  1  consumer accepts result.
- o_result  out  W+1  sum; bit W is the final carry-out.
- o_busy  out  1  high in ADD or DONE.

## Operation
- FSM states: IDLE, ADD, DONE.
- IDLE: o_ready=1. On i_valid&&o_ready:
  - latch A, B and i_carry_in into the carry register;
  - set chunk index idx=0;
  - go to ADD.
- ADD: each cycle computes {cout,sum} = A[idx] + B[idx] + carry, where X[idx] = bits idx*CHUNK_W +: CHUNK_W, using the chunk adder.
  - sum is written into o_result chunk idx; carry <= cout.
  - If idx==NUM_CHUNKS-1: o_result[W] <= cout and go to DONE. Otherwise idx++.
- DONE: o_valid=1, and o_result is held stable. On i_ready, go to IDLE.
- i_valid outside IDLE is ignored, and no operand is latched. Operand inputs may change freely after acceptance.
- Arithmetic is unsigned modulo 2^(W+1). Overflow never happens because the carry-out is bit W.
- idx is $clog2(NUM_CHUNKS) bits wide (min 1). idx is never compared past NUM_CHUNKS-1.
- Reset, from any state including mid-ADD: next state is IDLE, idx=0, carry=0, o_result=0, o_valid=0. The in-flight operation is discarded and no result is produced.
- Reset values: o_valid=0, o_busy=0, o_result=0. o_ready=0 while i_rst is high, and 1 in the first cycle after reset deasserts.

## Timing
- Acceptance is at edge T. The chunk computations happen on edges T+1 … T+NUM_CHUNKS. o_valid is high from edge T+NUM_CHUNKS onward. Latency is NUM_CHUNKS cycles.
- Result handshake at edge R → IDLE at R. o_ready is high in cycle R+1, and the earliest new accept is at edge R+1.
- Peak throughput is one operation per NUM_CHUNKS+2 cycles.
- o_valid, o_ready and o_busy are decoded from the state register only. o_ready is additionally gated by i_rst. There is no combinational path from i_valid or i_ready to any output.
- The critical path is one CHUNK_W-bit ripple plus the carry-register setup.

## Structure
- Package rca_ctrl_pkg holds:
  - the state enum (IDLE, ADD, DONE);
  - the default CHUNK_W and NUM_CHUNKS constants.
- Sub-module rca_chunk_adder: purely combinational CHUNK_W-bit ripple-carry adder built from per-bit full adders.
  - Ports: a, b, cin, sum, cout.
  - Instantiated once.
- The controller holds all registers: FSM, idx, carry, latched operands, result.

## Test plan
Defaults are CHUNK_W=10, NUM_CHUNKS=4, W=40.
- A=40'hFF_FFFF_FFFF, B=1, cin=0 → o_result=41'h100_0000_0000, with o_valid exactly 4 cycles after accept.
- A=0, B=0, cin=1 → o_result=1. A=40'h3FF, B=1 → 41'h400: the carry crosses the chunk 0/1 boundary.
- Backpressure: hold i_ready=0 for 5 cycles in DONE → o_valid stays 1 and o_result stays stable. o_ready stays 0, and i_valid pulses are not accepted.
- Reset asserted for 1 cycle while idx=2 → next cycle in IDLE with o_valid=0 and o_result=0; o_ready=1 after deassertion. A following add of 5+7 returns 12.
- 1000 random operand pairs with random cin, random i_valid and random i_ready, checked against a W+1-bit reference model. Check one result per accept, in order.
- Also run NUM_CHUNKS=1: result valid 1 cycle after accept, and 10'h3FF+10'h001 → 11'h400.
